// File: rtl/arb_pkg.sv
// ----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the matrix arbiter family.
//   ARB_MAX_WIDTH    : largest supported requester count (32)
//   arb_lock_state_e : lock FSM states (IDLE, LOCKED)
//   arb_is_onehot    : 1 when exactly one of the low `width` bits of vec is set
//   arb_tri_idx      : flat index of upper-triangle bit (i,j), i<j
// ----------------------------------------------------------------------------
package arb_pkg;

  localparam int ARB_MAX_WIDTH = 32;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_lock_state_e;

  function automatic logic arb_is_onehot(logic [31:0] vec, int width);
    int cnt;
    cnt = 0;
    for (int i = 0; i < ARB_MAX_WIDTH; i++) begin
      if ((i < width) && vec[i]) begin
        cnt = cnt + 1;
      end
    end
    return (cnt == 1);
  endfunction

  // Row-major packing of the strict upper triangle: row i holds
  // (width-1-i) bits, so row i starts after sum_{k<i}(width-1-k) bits.
  function automatic int arb_tri_idx(int i, int j, int width);
    return (i * width) - ((i * (i + 1)) / 2) + (j - i - 1);
  endfunction

endpackage

// File: rtl/arb_onehot_chk.sv
// ----------------------------------------------------------------------------
// arb_onehot_chk
// Combinational one-hot / all-zero detector for a WIDTH-bit vector.
//   vec       : vector under test
//   is_onehot : exactly one bit of vec is set
//   is_zero   : no bit of vec is set
// ----------------------------------------------------------------------------
module arb_onehot_chk
  import arb_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] vec,
  output logic             is_onehot,
  output logic             is_zero
);

  logic [ARB_MAX_WIDTH-1:0] ext_s;

  // Zero-extend to the package function's fixed argument width.
  always_comb begin
    ext_s             = {ARB_MAX_WIDTH{1'b0}};
    ext_s[WIDTH-1:0]  = vec;
  end

  assign is_onehot = arb_is_onehot(ext_s, WIDTH);
  assign is_zero   = (vec == {WIDTH{1'b0}});

endmodule

// File: rtl/arb_matrix_prio.sv
// ----------------------------------------------------------------------------
// arb_matrix_prio
// Least-recently-granted priority matrix keeper with multi-beat lock.
//   clk, rst     : clock, synchronous active-high reset
//   v_grant      : one-hot grant, sampled when gnt_fire=1
//   gnt_fire     : granted beat accepted this cycle
//   gnt_last     : accepted beat ends the transfer (qualified by gnt_fire)
//   vv_matrix    : vv_matrix[i][j]=1 means requester i beats requester j
//   lock_vld     : multi-beat transfer in progress
//   lock_onehot  : locked requester, zero when not locked
//   err_onehot   : sticky, fire seen with non-one-hot v_grant
//   err_lock     : sticky, fire in LOCKED with v_grant != lock_onehot
// ----------------------------------------------------------------------------
module arb_matrix_prio
  import arb_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH-1:0]            v_grant,
  input  logic                        gnt_fire,
  input  logic                        gnt_last,
  output logic [WIDTH-1:0][WIDTH-1:0] vv_matrix,
  output logic                        lock_vld,
  output logic [WIDTH-1:0]            lock_onehot,
  output logic                        err_onehot,
  output logic                        err_lock
);

  localparam int NUM_TRI = (WIDTH * (WIDTH - 1)) / 2;

  arb_lock_state_e  state_r;
  logic [NUM_TRI-1:0] tri_r;
  logic [NUM_TRI-1:0] tri_upd_s;
  logic [WIDTH-1:0]   lock_onehot_r;
  logic [WIDTH-1:0]   win_s;
  logic               err_onehot_r;
  logic               err_lock_r;
  logic               grant_onehot_s;
  logic               grant_zero_s;
  logic               grant_ok_s;

  arb_onehot_chk #(
    .WIDTH (WIDTH)
  ) u_grant_chk (
    .vec       (v_grant),
    .is_onehot (grant_onehot_s),
    .is_zero   (grant_zero_s)
  );

  assign grant_ok_s = grant_onehot_s & ~grant_zero_s;

  // Winner for a matrix update: the captured requester while locked,
  // otherwise the incoming grant.
  always_comb begin
    if (state_r == LOCKED) begin
      win_s = lock_onehot_r;
    end else begin
      win_s = v_grant;
    end
  end

  // Only the strict upper triangle is stored; diagonal and lower triangle
  // are derived so the antisymmetry invariant cannot be violated.
  for (genvar i = 0; i < WIDTH; i++) begin : g_row
    for (genvar j = 0; j < WIDTH; j++) begin : g_col
      if (i == j) begin : g_diag
        assign vv_matrix[i][j] = 1'b1;
      end else if (i < j) begin : g_upper
        localparam int K = arb_tri_idx(i, j, WIDTH);
        assign vv_matrix[i][j] = tri_r[K];
        // Winner i loses to everyone; winner j makes i beat j.
        assign tri_upd_s[K] = win_s[i] ? 1'b0 :
                              (win_s[j] ? 1'b1 : tri_r[K]);
      end else begin : g_lower
        localparam int K = arb_tri_idx(j, i, WIDTH);
        assign vv_matrix[i][j] = ~tri_r[K];
      end
    end
  end

  // Lock FSM, priority matrix storage and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      tri_r         <= {NUM_TRI{1'b1}};
      lock_onehot_r <= {WIDTH{1'b0}};
      err_onehot_r  <= 1'b0;
      err_lock_r    <= 1'b0;
    end else if (gnt_fire) begin
      if (!grant_ok_s) begin
        err_onehot_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          // A malformed grant in IDLE is flagged but otherwise ignored.
          if (grant_ok_s && gnt_last) begin
            tri_r <= tri_upd_s;
          end else if (grant_ok_s) begin
            state_r       <= LOCKED;
            lock_onehot_r <= v_grant;
          end
        end
        LOCKED: begin
          // The beat counts for the captured winner whatever v_grant says.
          if (v_grant != lock_onehot_r) begin
            err_lock_r <= 1'b1;
          end
          if (gnt_last) begin
            tri_r         <= tri_upd_s;
            lock_onehot_r <= {WIDTH{1'b0}};
            state_r       <= IDLE;
          end
        end
        default: begin
          state_r       <= IDLE;
          lock_onehot_r <= {WIDTH{1'b0}};
        end
      endcase
    end
  end

  assign lock_vld    = (state_r == LOCKED);
  assign lock_onehot = lock_onehot_r;
  assign err_onehot  = err_onehot_r;
  assign err_lock    = err_lock_r;

endmodule

// File: tb/tb_arb_matrix_prio.sv
// ----------------------------------------------------------------------------
// tb_arb_matrix_prio
// Scoreboard bench for arb_matrix_prio, WIDTH=4. Directed vectors push the
// hand-computed post-edge state; a monitor pops and compares after each edge
// and checks the matrix invariant every cycle.
// ----------------------------------------------------------------------------
module tb_arb_matrix_prio;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:0]      v_grant = 4'b0000;
  logic            gnt_fire = 1'b0;
  logic            gnt_last = 1'b0;
  logic [3:0][3:0] vv_matrix;
  logic            lock_vld;
  logic [3:0]      lock_onehot;
  logic            err_onehot;
  logic            err_lock;

  typedef struct {
    int          id;
    logic [15:0] m;
    logic        lv;
    logic [3:0]  lo;
    logic        eo;
    logic        el;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   vec_id   = 0;
  bit   inv_en   = 1'b0;

  arb_matrix_prio #(
    .WIDTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .v_grant     (v_grant),
    .gnt_fire    (gnt_fire),
    .gnt_last    (gnt_last),
    .vv_matrix   (vv_matrix),
    .lock_vld    (lock_vld),
    .lock_onehot (lock_onehot),
    .err_onehot  (err_onehot),
    .err_lock    (err_lock)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int id,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%h required=%h", name, id, act, req);
    end
  endtask

  // Drive one vector and record the state expected after the next edge.
  task automatic step(input logic r, input logic f, input logic l,
                      input logic [3:0] g, input logic [15:0] m,
                      input logic lv, input logic [3:0] lo,
                      input logic eo, input logic el);
    exp_t e;
    @(negedge clk);
    rst      = r;
    gnt_fire = f;
    gnt_last = l;
    v_grant  = g;
    e.id = vec_id;
    e.m  = m;
    e.lv = lv;
    e.lo = lo;
    e.eo = eo;
    e.el = el;
    sb_q.push_back(e);
    vec_id++;
  endtask

  // Monitor: compare against the scoreboard and check the invariant.
  initial begin
    exp_t        e;
    logic [15:0] mflat;
    logic        inv_ok;
    forever begin
      @(posedge clk);
      #1;
      mflat = vv_matrix;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("matrix", e.id, 32'(mflat), 32'(e.m));
        chk("lock_vld", e.id, 32'(lock_vld), 32'(e.lv));
        chk("lock_onehot", e.id, 32'(lock_onehot), 32'(e.lo));
        chk("err_onehot", e.id, 32'(err_onehot), 32'(e.eo));
        chk("err_lock", e.id, 32'(err_lock), 32'(e.el));
        inv_en = 1'b1;
      end
      if (inv_en) begin
        inv_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
          for (int j = 0; j < 4; j++) begin
            if (i == j) begin
              if (vv_matrix[i][j] !== 1'b1) inv_ok = 1'b0;
            end else begin
              if (vv_matrix[i][j] !== ~vv_matrix[j][i]) inv_ok = 1'b0;
            end
          end
        end
        chk("invariant", -1, 32'(inv_ok), 32'd1);
        if (!lock_vld) begin
          chk("lock_zero_idle", -1, 32'(lock_onehot), 32'd0);
        end
      end
    end
  end

  // Stimulus.
  initial begin
    //    rst   fire  last  grant    matrix    lv    lock     eo    el
    step(1'b1, 1'b0, 1'b0, 4'b0000, 16'h8CEF, 1'b0, 4'b0000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 4'b1111, 16'h8CEF, 1'b0, 4'b0000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 4'b0001, 16'h9DF1, 1'b0, 4'b0000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'b0100, 16'h9DF1, 1'b1, 4'b0100, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'b0100, 16'h9DF1, 1'b1, 4'b0100, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 4'b0100, 16'hD4F5, 1'b0, 4'b0000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 4'b0110, 16'hD4F5, 1'b0, 4'b0000, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 4'b0000, 16'hD4F5, 1'b0, 4'b0000, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'b0000, 16'hD4F5, 1'b0, 4'b0000, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'b0010, 16'hD4F5, 1'b1, 4'b0010, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 4'b1000, 16'hF627, 1'b0, 4'b0000, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 4'b0001, 16'hF627, 1'b1, 4'b0001, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 4'b0001, 16'h8CEF, 1'b0, 4'b0000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 4'b0000, 16'h8CEF, 1'b0, 4'b0000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 4'b0010, 16'hAE2F, 1'b0, 4'b0000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 4'b0001, 16'hBF31, 1'b0, 4'b0000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 4'b0100, 16'hF475, 1'b0, 4'b0000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'b1000, 16'hF475, 1'b1, 4'b1000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'b1001, 16'hF475, 1'b1, 4'b1000, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 4'b1000, 16'h8CFD, 1'b0, 4'b0000, 1'b1, 1'b1);

    // Random fire sequences; only the invariant is checked here.
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 49) == 0);
      gnt_fire = 1'($urandom_range(0, 1));
      gnt_last = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        v_grant = 4'($urandom_range(0, 15));
      end else begin
        v_grant = 4'(4'b0001 << $urandom_range(0, 3));
      end
    end

    @(negedge clk);
    rst      = 1'b0;
    gnt_fire = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
